// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// instruction size and the fetch-address legality check.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned INSN_BYTES      = 4;
    localparam logic [31:0] IMEM_FAULT_DATA = 32'hFFFF_FFFF;

    // A PC is unfetchable if it is not word aligned or lies past the last word.
    function automatic logic pc_is_bad(input logic [63:0] pc, input int unsigned words);
        return (pc[1:0] != 2'b00) || (pc[63:2] >= 62'(words));
    endfunction

endpackage

// File: rtl/fetch_out_buffer.sv
// One-entry valid/ready output register with flush; holds the most recently
// fetched instruction and its byte address until the consumer accepts it.
module fetch_out_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] inst_i,
    input  logic [63:0] pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q,  inst_d;
    logic [63:0] pc_q,    pc_d;

    // Flush wins over load; a plain accept empties the entry.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Sequential instruction fetch controller with redirect, back-pressure and
// out-of-range / misaligned fetch fault latching.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [63:0]  fault_pc_q, fault_pc_d;

    logic         buf_valid;
    logic         buf_load;
    logic         buf_flush;
    logic         slot_free;
    logic         pc_bad;
    logic [31:0]  fetch_data;

    assign imem_addr  = {2'b00, pc_q[63:2]};
    assign slot_free  = !buf_valid || out_ready;
    assign pc_bad     = pc_is_bad(pc_q, IMEM_WORDS);
    assign fetch_data = pc_bad ? IMEM_FAULT_DATA : imem_data;

    // Redirect overrides every state; otherwise RUN fetches whenever the
    // output slot is free or being emptied this cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;

        if (redirect_valid) begin
            buf_flush = 1'b1;
            pc_d      = redirect_pc;
            fault_d   = 1'b0;
            state_d   = start ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end else if (slot_free) begin
                        if (pc_bad) begin
                            state_d    = ST_FAULT;
                            fault_d    = 1'b1;
                            fault_pc_d = pc_q;
                            buf_flush  = 1'b1;
                        end else begin
                            buf_load = 1'b1;
                            pc_d     = pc_q + 64'(INSN_BYTES);
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_out_buffer u_out_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (buf_flush),
        .load_i  (buf_load),
        .inst_i  (fetch_data),
        .pc_i    (pc_q),
        .ready_i (out_ready),
        .valid_o (buf_valid),
        .inst_o  (out_inst),
        .pc_o    (out_pc)
    );

    assign out_valid = buf_valid;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a behavioural fetch model,
// preceded by directed scenarios for reset, stall, end-of-memory and redirect.
module tb_fetch_controller;

    localparam int unsigned WORDS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;

    logic [31:0] mem [WORDS];

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Model: a running flag, a fault flag, next PC and the single held instruction.
    bit          m_run;
    bit          m_fault;
    logic [63:0] m_fault_pc;
    logic [63:0] m_pc;
    bit          m_valid;
    logic [31:0] m_inst;
    logic [63:0] m_opc;

    fetch_controller #(
        .RESET_PC   (64'd0),
        .IMEM_WORDS (WORDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 64'(WORDS)) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_run = 0; m_fault = 0; m_fault_pc = '0; m_pc = '0;
        m_valid = 0; m_inst = '0; m_opc = '0;
    endtask

    // One clock edge of intended behaviour, from the current inputs.
    task automatic model_step();
        bit taken;
        taken = m_valid && out_ready;
        if (redirect_valid) begin
            m_valid = 0;
            m_pc    = redirect_pc;
            m_fault = 0;
            m_run   = start;
            return;
        end
        if (m_fault || !m_run) begin
            if (!m_fault && start) m_run = 1;
            if (taken) m_valid = 0;
            return;
        end
        if (!start) begin
            m_run = 0;
            if (taken) m_valid = 0;
            return;
        end
        if (m_valid && !out_ready) return;
        if ((m_pc % 4) != 0 || (m_pc / 4) >= 64'(WORDS)) begin
            m_fault    = 1;
            m_run      = 0;
            m_fault_pc = m_pc;
            m_valid    = 0;
            return;
        end
        m_valid = 1;
        m_inst  = mem[m_pc / 4];
        m_opc   = m_pc;
        m_pc    = m_pc + 4;
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_inst", 64'(out_inst), 64'(m_inst));
            check("out_pc", out_pc, m_opc);
        end
        check("fault", 64'(fault), 64'(m_fault));
        if (m_fault) check("fault_pc", fault_pc, m_fault_pc);
        check("imem_addr", imem_addr, m_pc / 4);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_inst", 64'(out_inst), 64'd0);
        check("rst_opc", out_pc, 64'd0);
        check("rst_fpc", fault_pc, 64'd0);
        check("rst_addr", imem_addr, 64'd0);
    endtask

    initial begin
        bit reached;
        for (int i = 0; i < int'(WORDS); i++) mem[i] = '0;
        mem[0] = 32'h0021_2783;
        mem[1] = 32'h0077_82B3;
        start = 0; redirect_valid = 0; redirect_pc = '0; out_ready = 1;
        rst_n = 1;
        @(negedge clk);
        async_reset();
        @(negedge clk);
        rst_n = 1; start = 1; out_ready = 1;

        // Straight-line fetch with consumer always ready.
        tick();
        tick();
        check("seq0_inst", 64'(out_inst), 64'h0021_2783);
        check("seq0_pc", out_pc, 64'd0);
        tick();
        check("seq1_inst", 64'(out_inst), 64'h0077_82B3);
        check("seq1_pc", out_pc, 64'd4);
        tick();
        check("seq2_inst", 64'(out_inst), 64'd0);
        check("seq2_pc", out_pc, 64'd8);

        // Reset in the middle of the stream.
        async_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        tick();
        check("rstart_pc", out_pc, 64'd0);

        // Three cycles of back-pressure after the first fetch.
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_inst", 64'(out_inst), 64'h0021_2783);
            check("stall_addr", imem_addr, 64'd1);
        end
        out_ready = 1;
        tick();
        check("resume_inst", 64'(out_inst), 64'h0077_82B3);
        check("resume_pc", out_pc, 64'd4);

        // Run off the end of memory.
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (out_valid && out_pc == 64'd124) reached = 1;
        end
        check("last_word_reached", 64'(reached), 64'd1);
        tick();
        check("eom_fault", 64'(fault), 64'd1);
        check("eom_fault_pc", fault_pc, 64'd128);
        check("eom_valid", 64'(out_valid), 64'd0);

        // Recover from the fault by redirecting to word 1.
        redirect_valid = 1; redirect_pc = 64'd4;
        tick();
        redirect_valid = 0;
        check("redir_fault_clr", 64'(fault), 64'd0);
        check("redir_bubble", 64'(out_valid), 64'd0);
        tick();
        check("redir_inst", 64'(out_inst), 64'h0077_82B3);
        check("redir_pc", out_pc, 64'd4);

        // Misaligned redirect while an instruction is held.
        out_ready = 0;
        tick();
        redirect_valid = 1; redirect_pc = 64'd6;
        tick();
        redirect_valid = 0;
        check("drop_valid", 64'(out_valid), 64'd0);
        tick();
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_fault_pc", fault_pc, 64'd6);

        // Randomized traffic against the model.
        for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 5))
                0:       redirect_pc = 64'($urandom_range(0, 35)) * 4 + 64'($urandom_range(1, 3));
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
                default: redirect_pc = 64'($urandom_range(0, WORDS - 1)) * 4;
            endcase
            if ($urandom_range(0, 199) == 0) async_reset();
            else rst_n = 1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 64'd0, byte address of the first fetch after reset.
REQ-002 Parameter IMEM_WORDS, default 32, number of instruction-memory words (addressed as word index).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; 1 = fetching enabled, 0 = hold current PC.
REQ-006 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-007 redirect_pc  input  64  redirect byte address.
REQ-008 imem_addr  output  64  word index to instruction memory, {2'b00, pc[63:2]}.
REQ-009 imem_data  input  32  combinational read data for imem_addr (same cycle).
REQ-010 out_valid  output  1  out_inst/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-012 out_inst  output  32  fetched instruction.
REQ-013 out_pc  output  64  byte address of out_inst.
REQ-014 fault  output  1  fetch fault latched.
REQ-015 fault_pc  output  64  PC that caused the fault.

Function
REQ-016 States SHALL be IDLE, RUN, FAULT; pc register 64 bits.
REQ-017 IDLE->RUN when start=1; RUN->IDLE when start=0 with no fetch that cycle; out buffer retained across IDLE.
REQ-018 A fetch SHALL occur in RUN when (!out_valid || out_ready) and no redirect: out_inst<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4 (64-bit wrap).
REQ-019 If out_valid && out_ready and no fetch, out_valid SHALL clear next cycle.
REQ-020 If out_valid && !out_ready, out_inst/out_pc/out_valid and pc SHALL hold unchanged.
REQ-021 Latency: instruction at pc appears on out_* the cycle after the fetch edge; throughput one instruction/cycle with out_ready=1.
REQ-022 redirect_valid SHALL take priority over fetch and handshake: out_valid<=0 (held instruction dropped), pc<=redirect_pc, one bubble cycle; accepted in IDLE, RUN and FAULT.
REQ-023 Fault condition: pc[63:2] >= IMEM_WORDS or pc[1:0] != 0, evaluated in RUN when a fetch would occur.
REQ-024 On fault: state<=FAULT, fault<=1, fault_pc<=pc, out_valid<=0, no pc increment, imem_data ignored.
REQ-025 FAULT SHALL hold until redirect_valid; redirect clears fault and goes to RUN if start=1 else IDLE; a redirect to a bad target re-faults on the next fetch attempt.
REQ-026 Last legal word (pc=4*(IMEM_WORDS-1)) SHALL fetch normally; next sequential fetch faults.
REQ-027 Simultaneous redirect_valid and out_ready handshake: handshake counts as consumed, redirect applies, out_valid=0 next cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, out_valid=0, out_inst=0, out_pc=0, fault=0, fault_pc=0.
REQ-029 Reset mid-operation SHALL discard any held instruction and fault; first fetch after release is RESET_PC.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the state enum, INSN_BYTES=4, and IMEM_FAULT_DATA=32'hFFFFFFFF.
REQ-031 One sub-module fetch_out_buffer (one-entry valid/ready register with flush) is natural; memory stays external.
REQ-032 imem_addr SHALL be purely combinational from pc.

Verification (IMEM word0=32'h00212783, word1=32'h007782B3, others 0)
REQ-033 Reset release, start=1, out_ready=1 -> cycle 1 out_inst=00212783 out_pc=0; cycle 2 007782B3 pc=4; cycle 3 0 pc=8.
REQ-034 out_ready=0 for 3 cycles after first fetch -> out_inst stays 00212783, imem_addr stays 1, then resumes with 007782B3.
REQ-035 Run to pc=124 -> word 31 delivered, next cycle fault=1, fault_pc=128, out_valid=0.
REQ-036 In FAULT, redirect_pc=4 -> fault=0, one bubble, out_inst=007782B3 out_pc=4.
REQ-037 redirect_pc=6 while out_valid && !out_ready -> held instruction dropped, next attempt faults with fault_pc=6.
REQ-038 rst_n low mid-stream at pc=12 -> out_valid=0 immediately; after release first out_pc=0.
